// File: rtl/mem_core_ctrl.sv
// -----------------------------------------------------------------------------
// mem_core_ctrl
//
// Row-oriented memory core controller. Accepts one read/write request at a
// time and sequences it as ACT (row open) -> ACCESS (RE or WE strobe) ->
// PRE (row closed). A free-running refresh timer raises a refresh request
// every REF_INTERVAL cycles. The refresh is served from IDLE by holding one
// row open in REF and then precharging. Refresh rows are walked round-robin.
//
// Handshake: req_valid/req_ready follow strict valid/ready semantics. A
// request transfers on a rising clk edge where both are 1. The requester must
// hold req_valid, req_write and req_row stable until that edge. After the
// transfer the controller keeps its own copies, so later changes on the
// request inputs have no effect on the access in flight.
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   access request present
//   req_ready    out  controller can accept a request (IDLE, no refresh due)
//   req_write    in   1 = write, 0 = read; sampled on accept
//   req_row      in   target row; sampled on accept
//   RowAddrEn    out  one-hot row enable to the core
//   RE / WE      out  read / write enable to the core (ACCESS cycle only)
//   rsp_done     out  one-cycle pulse in the first PRE cycle after ACCESS
//   rsp_write    out  write bit of the completed access, valid with rsp_done
//   busy         out  state is not IDLE
//   ref_overrun  out  sticky: refresh timer expired while a refresh was due
// -----------------------------------------------------------------------------
module mem_core_ctrl #(
    parameter int ROW_ADDR_BITWIDTH = 8,
    parameter int T_RCD             = 2,
    parameter int T_RP              = 2,
    parameter int T_RAS_REF         = 3,
    parameter int REF_INTERVAL      = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_write,
    input  logic [ROW_ADDR_BITWIDTH-1:0]        req_row,
    output logic [(2**ROW_ADDR_BITWIDTH)-1:0]   RowAddrEn,
    output logic                                RE,
    output logic                                WE,
    output logic                                rsp_done,
    output logic                                rsp_write,
    output logic                                busy,
    output logic                                ref_overrun
);

    localparam int PH_MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int PH_MAX   = (PH_MAX_A > T_RAS_REF) ? PH_MAX_A : T_RAS_REF;
    localparam int PH_W     = $clog2(PH_MAX + 1);
    localparam int RC_W     = $clog2(REF_INTERVAL);

    // Phase counters are loaded with (length - 1) and count down to 0.
    localparam logic [PH_W-1:0] RCD_LOAD = PH_W'(T_RCD - 1);
    localparam logic [PH_W-1:0] RP_LOAD  = PH_W'(T_RP - 1);
    localparam logic [PH_W-1:0] RAS_LOAD = PH_W'(T_RAS_REF - 1);
    localparam logic [RC_W-1:0] REF_LOAD = RC_W'(REF_INTERVAL - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACT    = 3'd1,
        ST_ACCESS = 3'd2,
        ST_PRE    = 3'd3,
        ST_REF    = 3'd4
    } state_e;

    state_e                         state_q, state_d;
    logic [PH_W-1:0]                ph_cnt_q, ph_cnt_d;
    logic [ROW_ADDR_BITWIDTH-1:0]   row_q, row_d;
    logic                           wr_q, wr_d;
    logic [ROW_ADDR_BITWIDTH-1:0]   ref_ptr_q, ref_ptr_d;
    logic                           ref_pend_q, ref_pend_d;
    logic                           ref_ovr_q, ref_ovr_d;
    logic [RC_W-1:0]                ref_cnt_q, ref_cnt_d;
    logic                           done_q, done_d;

    logic                           ref_expire;
    logic                           ref_leave;

    assign ref_expire = (ref_cnt_q == '0);
    assign ref_leave  = (state_q == ST_REF) && (ph_cnt_q == '0);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ph_cnt_q   <= '0;
            row_q      <= '0;
            wr_q       <= 1'b0;
            ref_ptr_q  <= '0;
            ref_pend_q <= 1'b0;
            ref_ovr_q  <= 1'b0;
            ref_cnt_q  <= REF_LOAD;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            row_q      <= row_d;
            wr_q       <= wr_d;
            ref_ptr_q  <= ref_ptr_d;
            ref_pend_q <= ref_pend_d;
            ref_ovr_q  <= ref_ovr_d;
            ref_cnt_q  <= ref_cnt_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        row_d    = row_q;
        wr_d     = wr_q;
        unique case (state_q)
            ST_IDLE: begin
                // A due refresh wins over a simultaneous request.
                if (ref_pend_q) begin
                    state_d  = ST_REF;
                    ph_cnt_d = RAS_LOAD;
                end else if (req_valid) begin
                    state_d  = ST_ACT;
                    ph_cnt_d = RCD_LOAD;
                    row_d    = req_row;
                    wr_d     = req_write;
                end
            end
            ST_ACT: begin
                if (ph_cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    ph_cnt_d = ph_cnt_q - 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d  = ST_PRE;
                ph_cnt_d = RP_LOAD;
            end
            ST_PRE: begin
                if (ph_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    ph_cnt_d = ph_cnt_q - 1'b1;
                end
            end
            ST_REF: begin
                if (ph_cnt_q == '0) begin
                    state_d  = ST_PRE;
                    ph_cnt_d = RP_LOAD;
                end else begin
                    ph_cnt_d = ph_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ph_cnt_d = '0;
            end
        endcase
    end

    // Refresh bookkeeping runs in every state.
    always_comb begin
        ref_cnt_d  = ref_expire ? REF_LOAD : (ref_cnt_q - 1'b1);
        // A new expiry re-arms the request even on the edge that retires
        // the previous refresh.
        ref_pend_d = ref_expire | (ref_pend_q & ~ref_leave);
        // An expiry that finds the flag still set is a missed refresh, even
        // if that refresh is finishing on the same edge.
        ref_ovr_d  = ref_ovr_q | (ref_expire & ref_pend_q);
        ref_ptr_d  = ref_leave ? (ref_ptr_q + 1'b1) : ref_ptr_q;
        // rsp_done is the registered "was in ACCESS" flag, so it lands in the
        // first PRE cycle after an access and never after REF.
        done_d     = (state_q == ST_ACCESS);
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state so reset clears them at once
    // ------------------------------------------------------------------
    always_comb begin
        RowAddrEn = '0;
        RE        = 1'b0;
        WE        = 1'b0;
        unique case (state_q)
            ST_ACT: begin
                RowAddrEn[row_q] = 1'b1;
            end
            ST_ACCESS: begin
                RowAddrEn[row_q] = 1'b1;
                RE               = ~wr_q;
                WE               = wr_q;
            end
            ST_REF: begin
                RowAddrEn[ref_ptr_q] = 1'b1;
            end
            default: begin
                RowAddrEn = '0;
            end
        endcase
        req_ready   = (state_q == ST_IDLE) && !ref_pend_q;
        busy        = (state_q != ST_IDLE);
        rsp_done    = done_q;
        rsp_write   = done_q & wr_q;
        ref_overrun = ref_ovr_q;
    end

endmodule
